// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: on-chip register-file dump engine.
// When triggered by a start pulse, or by the PC arriving at HALT_PC, it
// halts the CPU. It then walks the CPU debug read port over x0..x[NREGS-1].
// The output is one header word (the trigger PC) followed by every register
// value, sent on a valid/ready stream to a downstream formatter.
module regfile_dump_ctrl #(
  parameter int              NREGS   = 32,
  parameter int              SELW    = 5,
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   HALT_PC = 32'h0000_0048
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   pc_in,
  output logic [SELW-1:0] reg_sel,
  input  logic [DW-1:0]   reg_data,
  output logic            cpu_halt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEL,
    S_XFER,
    S_DONE
  } state_e;

  localparam logic [SELW-1:0] LAST_IDX = SELW'(NREGS - 1);

  state_e          state_q, state_d;
  logic [SELW-1:0] idx_q,   idx_d;
  logic [DW-1:0]   data_q,  data_d;
  logic            armed_q, armed_d;

  logic pc_at_halt;
  logic trigger;

  assign pc_at_halt = (pc_in == HALT_PC);
  // A start pulse and a PC match in the same cycle still give one trigger.
  assign trigger    = start | (armed_q & pc_at_halt);

  // Next-state logic for the dump sequencer and the auto-trigger arm flag.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_HDR;
          data_d  = pc_in;
          idx_d   = '0;
        end
      end
      S_HDR: begin
        if (out_ready) state_d = S_SEL;
      end
      S_SEL: begin
        // x0 is hardwired to zero, so do not trust the read port for it.
        data_d  = (idx_q == '0) ? '0 : reg_data;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SEL;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Re-arm whenever the PC leaves HALT_PC. Disarm at the end of a dump,
    // so that each arrival at HALT_PC gives only one auto-dump.
    if (!pc_at_halt)            armed_d = 1'b1;
    else if (state_q == S_DONE) armed_d = 1'b0;
    else                        armed_d = armed_q;
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      armed_q <= armed_d;
    end
  end

  // Outputs are decoded from the registered state only.
  always_comb begin
    reg_sel   = idx_q;
    out_data  = data_q;
    out_valid = (state_q == S_HDR) || (state_q == S_XFER);
    out_last  = (state_q == S_XFER) && (idx_q == LAST_IDX);
    busy      = (state_q != S_IDLE);
    cpu_halt  = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb_regfile_dump_ctrl: directed plus randomized checks of the register dump
// engine against a queue-based model of the expected word stream.
module tb_regfile_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pc_in;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        cpu_halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  // The CPU register file seen through the debug port.
  logic [31:0] regs [32];
  assign reg_data = regs[reg_sel];

  regfile_dump_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pc_in     (pc_in),
    .reg_sel   (reg_sel),
    .reg_data  (reg_data),
    .cpu_halt  (cpu_halt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Monitor state.
  logic [31:0] got_q  [$];
  bit          last_q [$];
  logic [31:0] exp_q  [$];
  int          cyc, done_cnt, done_cyc, halt_cnt;
  bit          prev_stall;
  logic [31:0] prev_data;

  // Stimulus modes.
  bit rand_ready;
  bit extra_start;
  bit bp_arm;
  int hold_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected stream: the trigger PC, then x0 read as zero, then x1..x31.
  task automatic build_exp(input logic [31:0] pcv);
    exp_q.delete();
    exp_q.push_back(pcv);
    exp_q.push_back(32'h0);
    for (int i = 1; i < 32; i++) exp_q.push_back(regs[i]);
  endtask

  // One clock: sample at the falling edge, then drive just after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, prev_data);
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_data  = out_data;
    if (out_valid && out_ready && !rst) begin
      got_q.push_back(out_data);
      last_q.push_back(out_last);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cpu_halt) halt_cnt++;
    @(posedge clk);
    #1;
    if (bp_arm && out_valid && reg_sel == 5'd5) begin
      bp_arm    = 1'b0;
      hold_left = 5;
      out_ready = 1'b0;
    end else if (hold_left > 0) begin
      check("bp_data", out_data, 32'h1000_0005);
      check("bp_sel", 32'(reg_sel), 32'd5);
      hold_left--;
      if (hold_left == 0) out_ready = 1'b1;
    end
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    if (extra_start) start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic clear_monitor();
    got_q.delete();
    last_q.delete();
    cyc        = 0;
    done_cnt   = 0;
    done_cyc   = -1;
    halt_cnt   = 0;
    prev_stall = 1'b0;
  endtask

  // Trigger one dump, wait for it (bounded), idle for 'tail' cycles, then compare.
  task automatic run_dump(input string tag, input logic [31:0] pcv, input bit use_start,
                          input bit check_timing, input int tail);
    build_exp(pcv);
    pc_in = pcv;
    if (use_start) start = 1'b1;
    step();
    clear_monitor();
    start = 1'b0;
    for (int n = 0; n < 3000 && done_cnt == 0; n++) step();
    check({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    for (int n = 0; n < tail; n++) step();
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_words"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(i == exp_q.size() - 1));
    end
    if (check_timing) begin
      check({tag, "_done_cyc"}, 32'(done_cyc), 32'd66);
      check({tag, "_halt_cyc"}, 32'(halt_cnt), 32'd66);
    end
    check({tag, "_idle_halt"}, 32'(cpu_halt), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    pc_in       = 32'h40;
    out_ready   = 1'b1;
    rand_ready  = 1'b0;
    extra_start = 1'b0;
    bp_arm      = 1'b0;
    hold_left   = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    clear_monitor();

    // 1. Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel", 32'(reg_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halt", 32'(cpu_halt), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", out_data, 32'd0);
    rst = 1'b0;
    step();

    // 2. Full dump with no backpressure and exact timing.
    run_dump("full", 32'h40, 1'b1, 1'b1, 10);

    // 3. Backpressure while x5 is on the stream.
    bp_arm = 1'b1;
    run_dump("bp", 32'h40, 1'b1, 1'b0, 10);
    check("bp_fired", 32'(bp_arm), 32'd0);

    // 4. Auto-trigger: one dump per arrival at HALT_PC.
    run_dump("auto1", 32'h48, 1'b0, 1'b1, 150);
    pc_in = 32'h4C;
    step();
    run_dump("auto2", 32'h48, 1'b0, 1'b1, 20);
    pc_in = 32'h40;
    step();

    // 5. Reset while x10 is in transfer.
    build_exp(32'h40);
    start = 1'b1;
    step();
    start = 1'b0;
    clear_monitor();
    for (int n = 0; n < 200 && !(out_valid && reg_sel == 5'd10); n++) step();
    check("mid_found", 32'(reg_sel), 32'd10);
    rst = 1'b1;
    step();
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_halt", 32'(cpu_halt), 32'd0);
    check("mid_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    repeat (5) step();
    check("mid_no_done", 32'(done_cnt), 32'd0);
    run_dump("after_rst", 32'h40, 1'b1, 1'b1, 10);

    // 6. Constant all-ones register file, with start pulses while busy.
    for (int i = 0; i < 32; i++) regs[i] = 32'hFFFF_FFFF;
    extra_start = 1'b1;
    run_dump("ones", 32'h40, 1'b1, 1'b1, 20);
    extra_start = 1'b0;
    start = 1'b0;

    // Randomized register contents, PC and downstream ready.
    for (int t = 0; t < 3; t++) begin
      logic [31:0] rpc;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      rpc = $urandom;
      if (rpc == 32'h48) rpc = 32'h44;
      rand_ready = 1'b1;
      run_dump($sformatf("rand%0d", t), rpc, 1'b1, 1'b0, 10);
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
- Hardware counterpart of the simulation register-file probe. On a trigger (explicit start pulse or PC reaching a halt address), it stalls the CPU and walks the sccomp debug port (reg_sel/reg_data) over x0..x31.
- It emits a header word (the trigger PC) followed by all 32 register values on a valid/ready stream, for a UART/host formatter downstream.
- It sits beside sccomp at the top level and is the on-chip source of the same pc + rf00..rf31 dump the bench prints.

Parameters:
- NREGS, 32, number of registers dumped (indices 0..NREGS-1).
- SELW, 5, width of reg_sel.
- DW, 32, data width of registers, PC and stream.
- HALT_PC, 32'h00000048, PC value that auto-triggers a dump.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle dump request.
- pc_in  input  DW  current CPU PC.
- reg_sel  output  SELW  register index driven to the CPU debug read port.
- reg_data  input  DW  combinational read data for reg_sel.
- cpu_halt  output  1  stalls the CPU (PC and RF writes frozen) while high.
- out_valid  output  1  stream word valid.
- out_ready  input  1  downstream accepts word.
- out_data  output  DW  stream word.
- out_last  output  1  marks the final word (x[NREGS-1]).
- busy  output  1  dump in progress (any state other than IDLE).
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: state IDLE, idx=0, reg_sel=0, armed=1. cpu_halt, out_valid, out_last, busy and done are 0. out_data=0.
- trigger = start | (armed & pc_in==HALT_PC), sampled in IDLE only. start or a PC match while busy is ignored. A simultaneous start and PC match yields one dump.
- armed is cleared when a dump completes. It is set again on any cycle with pc_in!=HALT_PC. This gives one auto-dump per arrival at HALT_PC.
- IDLE -> HDR on trigger edge. The PC is latched into out_data. out_valid=1, cpu_halt=1, idx=0.
- HDR: hold the word until out_valid&out_ready, then go to SEL.
- SEL: reg_sel=idx, out_valid=0. At the next edge, capture reg_data into out_data (forced to 0 when idx==0). Set out_valid=1, set out_last=(idx==NREGS-1), go to XFER.
- XFER: out_data, out_last and reg_sel are held stable until the handshake.
  - On the handshake with idx<NREGS-1: idx++, go to SEL.
  - On the handshake with idx==NREGS-1: go to DONE.
- DONE: one cycle with done=1, cpu_halt=1, out_valid=0. Then go to IDLE, clear armed, set idx=0 and reg_sel=0. cpu_halt drops entering IDLE.
- Latency with out_ready=1 and the trigger sampled at edge 0:
  - HDR is cycle 1.
  - Register k occupies SEL at cycle 2+2k and XFER at cycle 3+2k.
  - DONE is cycle 66.
  - 33 words are transferred in total.
- Data rules:
  - No word is ever dropped or duplicated.
  - out_valid never deasserts without a handshake, except on rst.
  - out_last is high only on the final word.
- Reset mid-dump: the next cycle is in the reset state. No done pulse and no partial resume. A later trigger restarts from the header.
- idx never exceeds NREGS-1. No wrap.

Test Plan:
1. Reset: assert rst for 2 cycles -> all outputs 0, reg_sel=0, busy=0.
2. Full dump: reg_data=32'h10000000+reg_sel, pc_in=32'h40, out_ready=1, start pulse.
   - Required stream: 00000040, 00000000, 10000001 .. 1000001F (33 words).
   - out_last only on 1000001F.
   - done high exactly at cycle 66.
   - cpu_halt high for cycles 1..66.
3. Backpressure: in scenario 2, hold out_ready=0 for 5 cycles while word x5 is valid -> out_data stays 10000005, reg_sel stays 5, sequence resumes with 10000006, still 33 words total.
4. Auto-trigger: hold pc_in=32'h48 for 200 cycles -> exactly one dump with header 00000048. Set pc_in=32'h4C for 1 cycle, then 32'h48 again -> exactly one more dump.
5. Reset mid-dump: assert rst while x10 is in XFER -> next cycle busy=0, cpu_halt=0, out_valid=0, no done pulse. A following start gives a complete 33-word dump from the header.
6. x0 and ignored start: reg_data=32'hFFFFFFFF constant -> word for x0 is 00000000 and x1..x31 read FFFFFFFF. start pulses during busy cause no extra words and no second dump.
